// File: rtl/perceptron_pkg.sv
// Shared types and constants for the perceptron training controller.
// The optional PERCEPTRON_SHUFFLE_EN build only affects perceptron_addr_gen.
package perceptron_pkg;

    localparam int DATA_W    = 32;
    localparam int N_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SETTLE,
        COMPARE,
        NEXT,
        EPOCH_END,
        DONE
    } state_e;

endpackage

// File: rtl/perceptron_train_ctrl_if.sv
// Sample-memory and neuron/weights bus between the training controller
// (master) and the memory plus datapath (slave).
interface perceptron_train_ctrl_if #(
    parameter int N      = perceptron_pkg::N_DEFAULT,
    parameter int ADDR_W = 4
);
    import perceptron_pkg::*;

    // No valid/ready here: sample_x/sample_y are valid exactly one cycle after
    // sample_addr, and y is a combinational function of x and the weights.
    logic [ADDR_W-1:0] sample_addr;
    logic [N-1:0]      sample_x;
    logic [DATA_W-1:0] sample_y;
    logic [N-1:0]      x;
    logic [DATA_W-1:0] expected_y;
    logic [DATA_W-1:0] y;
    logic              train;

    modport master (
        output sample_addr, x, expected_y, train,
        input  sample_x, sample_y, y
    );

    modport slave (
        input  sample_addr, x, expected_y, train,
        output sample_x, sample_y, y
    );

endinterface

// File: rtl/perceptron_addr_gen.sv
// Sample index counter with last-index detect. With PERCEPTRON_SHUFFLE_EN the
// memory address is index XOR the low epoch bits; otherwise it is the index.
module perceptron_addr_gen
    import perceptron_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              inc_i,
    input  logic [ADDR_W-1:0] epoch_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] index_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index_q <= '0;
        end else if (clr_i) begin
            index_q <= '0;
        end else if (inc_i) begin
            index_q <= index_q + ADDR_W'(1);
        end
    end

    // End of epoch is decided on the index so shuffling never skips a sample.
    assign last_o = (index_q == {ADDR_W{1'b1}});

`ifdef PERCEPTRON_SHUFFLE_EN
    assign addr_o = index_q ^ epoch_i;
`else
    logic unused_epoch;
    assign unused_epoch = ^epoch_i;
    assign addr_o       = index_q;
`endif

endmodule

// File: rtl/perceptron_train_ctrl.sv
// Perceptron training sequencer: walks the sample memory per epoch and pulses
// train on misclassified samples. PERCEPTRON_SHUFFLE_EN permutes the visit order.
module perceptron_train_ctrl
    import perceptron_pkg::*;
#(
    parameter int N             = N_DEFAULT,
    parameter int ADDR_W        = 4,
    parameter int EPOCH_W       = 8,
    parameter int MAX_EPOCHS    = 200,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    perceptron_train_ctrl_if.master bus,
    output logic                   busy,
    output logic                   done,
    output logic                   converged,
    output logic [EPOCH_W-1:0]     epoch_count,
    output logic [ADDR_W:0]        error_count,
    output state_e                 dbg_state
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam int ERR_W = ADDR_W + 1;

    state_e             state_q;
    logic [N-1:0]       x_q;
    logic [DATA_W-1:0]  exp_y_q;
    logic               busy_q;
    logic               done_q;
    logic               conv_q;
    logic [EPOCH_W-1:0] epoch_q;
    logic [EPOCH_W-1:0] epoch_d;
    logic [ERR_W-1:0]   err_q;
    logic [ERR_W-1:0]   err_d;
    logic [CNT_W-1:0]   cnt_q;

    logic              mismatch;
    logic              at_limit;
    logic              idx_clr;
    logic              idx_inc;
    logic              idx_last;
    logic [ADDR_W-1:0] addr;

    assign mismatch = (bus.y != exp_y_q);
    assign epoch_d  = epoch_q + EPOCH_W'(1);
    assign err_d    = err_q + ERR_W'(1);
    assign at_limit = (epoch_d == EPOCH_W'(MAX_EPOCHS));

    always_comb begin
        idx_clr = 1'b0;
        idx_inc = 1'b0;
        if (state_q == IDLE && start) begin
            idx_clr = 1'b1;
        end
        if (state_q == EPOCH_END && err_q != '0 && !at_limit) begin
            idx_clr = 1'b1;
        end
        if (state_q == NEXT && !idx_last) begin
            idx_inc = 1'b1;
        end
    end

    perceptron_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (idx_clr),
        .inc_i   (idx_inc),
        .epoch_i (epoch_q[ADDR_W-1:0]),
        .addr_o  (addr),
        .last_o  (idx_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            exp_y_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            conv_q  <= 1'b0;
            epoch_q <= '0;
            err_q   <= '0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= FETCH;
                        busy_q  <= 1'b1;
                        conv_q  <= 1'b0;
                        epoch_q <= '0;
                        err_q   <= '0;
                    end
                end
                FETCH: state_q <= LOAD;
                LOAD: begin
                    x_q     <= bus.sample_x;
                    exp_y_q <= bus.sample_y;
                    cnt_q   <= CNT_W'(SETTLE_CYCLES);
                    state_q <= SETTLE;
                end
                SETTLE: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (mismatch) begin
                        err_q <= err_d;
                    end
                    state_q <= NEXT;
                end
                NEXT: state_q <= idx_last ? EPOCH_END : FETCH;
                EPOCH_END: begin
                    epoch_q <= epoch_d;
                    if (err_q == '0) begin
                        conv_q  <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (at_limit) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        err_q   <= '0;
                        state_q <= FETCH;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // train is decoded from the registered state so it is confined to the
    // COMPARE cycle and drops the instant rst moves the state to IDLE.
    assign bus.train       = (state_q == COMPARE) && mismatch;
    assign bus.sample_addr = addr;
    assign bus.x           = x_q;
    assign bus.expected_y  = exp_y_q;

    assign busy        = busy_q;
    assign done        = done_q;
    assign converged   = conv_q;
    assign epoch_count = epoch_q;
    assign error_count = err_q;
    assign dbg_state   = state_q;

endmodule
